// File: rtl/sd_spi_byte_engine_if.sv
// Host-side handshake between the Z80 I/O decode and the SD-card SPI byte engine.
// The master issues byte requests; the slave (the engine) reports busy and returns the received byte.
interface sd_spi_byte_engine_if;
  logic       start;
  logic       fast;
  logic [7:0] tx_data;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_load;

  modport master (
    output start,
    output fast,
    output tx_data,
    input  busy,
    input  rx_data,
    input  rx_load
  );

  modport slave (
    input  start,
    input  fast,
    input  tx_data,
    output busy,
    output rx_data,
    output rx_load
  );
endinterface

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte shifter for the SD-card port: shifts one byte out on MOSI while
// shifting MISO in, then presents the received byte with a one-clock rx_load pulse.
module sd_spi_byte_engine #(
  parameter int DIV_SLOW = 63,
  parameter int DIV_FAST = 1,
  parameter int DIVW     = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  sd_spi_byte_engine_if.slave   host,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  localparam logic [DIVW-1:0] DIV_SLOW_W = DIVW'(DIV_SLOW);
  localparam logic [DIVW-1:0] DIV_FAST_W = DIVW'(DIV_FAST);

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_max;
  logic            phase_end;
  logic [2:0]      bit_cnt;
  logic [6:0]      tx_sr;     // bits still to send; bit 7 goes straight to mosi at acceptance
  logic [7:0]      rx_sr;
  logic            rate_fast;
  logic            busy;
  logic [7:0]      rx_data;
  logic            rx_load;

  // Rate is taken from the flag captured at acceptance, never from the live fast input.
  always_comb begin
    div_max   = rate_fast ? DIV_FAST_W : DIV_SLOW_W;
    phase_end = (div_cnt == div_max);
  end

  // NOTE: every register below is updated with <= so all of them see pre-edge values;
  // blocking assignments here would let later statements read already-updated state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rate_fast <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
      rx_load   <= 1'b0;
    end else begin
      // NOTE: default-low here makes rx_load a single-cycle pulse without extra state.
      rx_load <= 1'b0;

      unique case (state)
        IDLE: begin
          if (host.start) begin
            tx_sr     <= host.tx_data[6:0];
            mosi      <= host.tx_data[7];
            rate_fast <= host.fast;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (phase_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sr   <= {rx_sr[6:0], miso};
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_cnt == 3'd7) begin
              // Last falling edge: the 8th MISO bit was captured on the preceding rise.
              mosi    <= 1'b1;
              busy    <= 1'b0;
              rx_data <= rx_sr;
              rx_load <= 1'b1;
              state   <= IDLE;
            end else begin
              mosi    <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              state   <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy    = busy;
  assign host.rx_data = rx_data;
  assign host.rx_load = rx_load;

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Directed bench for sd_spi_byte_engine: loopback, slow rate with a card model,
// mid-transfer reset, ignored start, back-to-back bytes and idle hold.
module tb_sd_spi_byte_engine;

  logic       clk;
  logic       clr;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       loop_en;
  logic       miso_drv;
  logic [7:0] card_byte;

  int total;
  int bad;

  int         lat;
  int         rises;
  int         hmin;
  int         hmax;
  int         loads;
  int         mlow;
  logic [7:0] mseq;
  logic       sclk_prev;

  sd_spi_byte_engine_if bus ();

  sd_spi_byte_engine #(
    .DIV_SLOW(63),
    .DIV_FAST(1),
    .DIVW    (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .host(bus),
    .miso(miso),
    .sclk(sclk),
    .mosi(mosi)
  );

  assign miso = loop_en ? mosi : miso_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One byte transfer from the acceptance edge up to the rx_load cycle (returns there).
  // In card mode, miso follows card_byte MSB first, changing after each falling sclk.
  task automatic xfer(input logic [7:0] tx, input logic f, input logic hold, input int ign_at,
                      output int o_lat, output int o_rises, output logic [7:0] o_mseq,
                      output int o_hmin, output int o_hmax, output int o_loads, output int o_mlow);
    int   last_t;
    int   falls;
    int   h;
    logic sp;
    bus.tx_data = tx;
    bus.fast    = f;
    bus.start   = 1'b1;
    if (!loop_en) miso_drv = card_byte[7];
    tick();
    if (!hold) bus.start = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_mosi", mosi, tx[7]);
    o_lat = -1; o_rises = 0; o_mseq = '0; o_hmin = 1000000; o_hmax = 0; o_loads = 0; o_mlow = 0;
    last_t = 0; falls = 0; sp = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (ign_at != 0 && c == ign_at) begin
        bus.start = 1'b1; bus.tx_data = 8'h00; bus.fast = ~f;
      end else if (ign_at != 0 && c == ign_at + 1) begin
        bus.start = 1'b0; bus.tx_data = tx; bus.fast = f;
      end
      tick();
      if (mosi === 1'b0) o_mlow++;
      if (sclk !== sp) begin
        h = c - last_t;
        last_t = c;
        if (h < o_hmin) o_hmin = h;
        if (h > o_hmax) o_hmax = h;
        if (sclk) begin
          o_rises++;
          o_mseq = {o_mseq[6:0], mosi};
        end else begin
          falls++;
          if (!loop_en && falls < 8) miso_drv = card_byte[7 - falls];
        end
        sp = sclk;
      end
      if (bus.rx_load) begin
        o_loads++;
        o_lat = c;
        break;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    clr = 1'b0; loop_en = 1'b1; miso_drv = 1'b1; card_byte = 8'h00;
    bus.start = 1'b0; bus.fast = 1'b0; bus.tx_data = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_load", bus.rx_load, 0);
    clr = 1'b1;
    tick();

    // Loopback, fast, A5
    xfer(8'hA5, 1'b1, 1'b0, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("lb_latency", lat, 32);
    check("lb_rises", rises, 8);
    check("lb_mosi_seq", mseq, 8'hA5);
    check("lb_half_min", hmin, 2);
    check("lb_half_max", hmax, 2);
    check("lb_rx_data", bus.rx_data, 8'hA5);
    check("lb_done_sclk", sclk, 0);
    check("lb_done_mosi", mosi, 1);
    check("lb_done_busy", bus.busy, 0);
    tick();
    check("lb_pulse_width", bus.rx_load, 0);
    check("lb_rx_hold", bus.rx_data, 8'hA5);

    // Abort by reset after 3 sclk rises
    bus.tx_data = 8'hA5; bus.fast = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rises = 0; sclk_prev = 1'b0;
    for (int c = 0; c < 200 && rises < 3; c++) begin
      tick();
      if (sclk && !sclk_prev) rises++;
      sclk_prev = sclk;
    end
    check("abort_rises", rises, 3);
    check("abort_busy_before", bus.busy, 1);
    #2 clr = 1'b0;
    #1;
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_rx_data", bus.rx_data, 8'h00);
    loads = 0;
    repeat (3) begin
      tick();
      if (bus.rx_load) loads++;
    end
    clr = 1'b1;
    repeat (40) begin
      tick();
      if (bus.rx_load) loads++;
    end
    check("abort_no_load", loads, 0);
    check("abort_idle_busy", bus.busy, 0);

    // Normal transfer after reset
    xfer(8'h3C, 1'b1, 1'b0, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("post_abort_latency", lat, 32);
    check("post_abort_rx", bus.rx_data, 8'h3C);
    tick();

    // Slow rate, card returns 3C, sends FF
    loop_en = 1'b0; card_byte = 8'h3C;
    xfer(8'hFF, 1'b0, 1'b0, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("slow_latency", lat, 1024);
    check("slow_half_min", hmin, 64);
    check("slow_half_max", hmax, 64);
    check("slow_rises", rises, 8);
    check("slow_mosi_seq", mseq, 8'hFF);
    check("slow_mosi_low_cycles", mlow, 0);
    check("slow_rx_data", bus.rx_data, 8'h3C);
    tick();

    // Start with tx_data=00 and toggled fast at cycle 10 of an FF transfer is ignored
    loop_en = 1'b1;
    xfer(8'hFF, 1'b1, 1'b0, 10, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("ign_latency", lat, 32);
    check("ign_mosi_seq", mseq, 8'hFF);
    check("ign_mosi_low_cycles", mlow, 0);
    check("ign_half_min", hmin, 2);
    check("ign_half_max", hmax, 2);
    check("ign_rx_data", bus.rx_data, 8'hFF);
    loads = 0;
    repeat (40) begin
      tick();
      if (bus.rx_load) loads++;
    end
    check("ign_single_load", loads, 0);
    check("ign_idle_busy", bus.busy, 0);

    // Back-to-back with start held high: 12 then 34
    xfer(8'h12, 1'b1, 1'b1, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("b2b_first_latency", lat, 32);
    check("b2b_first_rx", bus.rx_data, 8'h12);
    check("b2b_gap_busy_low", bus.busy, 0);
    xfer(8'h34, 1'b1, 1'b0, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("b2b_pulse_spacing", lat + 1, 33);
    check("b2b_second_rx", bus.rx_data, 8'h34);
    check("b2b_second_mosi_seq", mseq, 8'h34);
    tick();

    // Hold: 5A from the card, then 200 idle cycles with miso toggling
    loop_en = 1'b0; card_byte = 8'h5A;
    xfer(8'hC3, 1'b1, 1'b0, 0, lat, rises, mseq, hmin, hmax, loads, mlow);
    check("hold_xfer_latency", lat, 32);
    check("hold_xfer_rx", bus.rx_data, 8'h5A);
    for (int i = 0; i < 200; i++) begin
      miso_drv = ~miso_drv;
      tick();
      check("hold_rx_data", bus.rx_data, 8'h5A);
      check("hold_rx_load", bus.rx_load, 0);
      check("hold_sclk", sclk, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_byte_engine.md
Name: sd_spi_byte_engine

Overview:
- SPI mode-0 byte shifter serving the SD-card port of the Z80 SBC.
- Accepts a byte write from the I/O decode and shifts it out on MOSI while shifting MISO in.
- Presents the received byte on rx_data with a one-cycle rx_load pulse. rx_load drives the load input of the downstream clocked clear-able read-back latch, and rx_data drives that latch's data input.
- Chip-select is not handled here; it comes from a separate control latch.

Parameters:
- DIV_SLOW, 63, half-period of SCLK in clk cycles minus 1 while fast=0 (SD init rate).
- DIV_FAST, 1, half-period of SCLK in clk cycles minus 1 while fast=1.
- DIVW, 8, width of the divider counter; must hold max(DIV_SLOW, DIV_FAST).

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  transfer request, sampled on clk; honoured only in IDLE.
- fast  input  1  rate select, captured at start acceptance.
- tx_data  input  8  byte to send, captured at start acceptance.
- miso  input  1  serial data from card; already synchronised upstream.
- sclk  output  1  SPI clock, idle 0.
- mosi  output  1  SPI data out, idle 1.
- busy  output  1  high while a transfer is in progress.
- rx_data  output  8  last received byte, MSB first.
- rx_load  output  1  one-clk pulse marking rx_data as newly valid.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE.
  - Outputs: sclk=0, mosi=1, busy=0, rx_data=8'h00, rx_load=0.
  - Divider, bit counter and shift registers are cleared.
  - Asserting clr mid-transfer aborts the transfer immediately; no rx_load is produced for the aborted byte.
- States: IDLE, SHIFT_LO (sclk=0 phase), SHIFT_HI (sclk=1 phase).
- Let D = DIV_FAST if the captured fast=1, else DIV_SLOW. Each phase lasts D+1 clk cycles.
- Start acceptance, at clk edge E0 with state IDLE and start=1:
  - Capture tx_data into the tx shift register and fast into the rate flag.
  - busy=1 and mosi=tx_data[7] from E0.
  - Enter SHIFT_LO with bit counter = 0.
- start while busy=1 is ignored: no queuing, no effect on the transfer in progress.
- SHIFT_LO -> SHIFT_HI after D+1 cycles:
  - sclk goes 1 at E0+(2k+1)(D+1), k = 0..7.
  - miso is sampled into rx shift register bit 0 at that edge (shift left).
- SHIFT_HI -> SHIFT_LO after D+1 cycles:
  - sclk goes 0 and the tx shift register shifts left, so mosi presents the next bit.
  - The bit counter increments.
- On the 8th falling transition, at E0+16(D+1):
  - State goes to IDLE, sclk=0, mosi=1, busy=0.
  - rx_data is loaded from the rx shift register and rx_load=1 for exactly that one cycle.
- Latency: start edge to rx_load = 16(D+1) clk cycles.
  - D=1 gives 32 cycles.
  - D=63 gives 1024 cycles.
- Back-to-back: start asserted in the rx_load cycle is sampled on the next edge, where state=IDLE, and accepted there. Minimum inter-byte gap is 1 clk cycle.
- rx_data holds its value between transfers; it changes only on a completion cycle or on reset.
- Changing fast or tx_data during a transfer has no effect until the next acceptance.
- miso is ignored outside the rising-sclk sample edges.

Test Plan:
- Reset: drive clr=0 mid-transfer (DIV_FAST, after 3 sclk rises) -> same cycle sclk=0, mosi=1, busy=0, rx_data=00, rx_load never pulses; after clr=1 the next start behaves normally.
- Loopback, fast: miso tied to mosi, fast=1, start with tx_data=A5 -> 8 sclk pulses of 2-cycle half-period, mosi sequence 1,0,1,0,0,1,0,1, rx_load high exactly 32 cycles after start edge, rx_data=A5.
- Slow rate: fast=0, card model returns 3C, tx_data=FF -> sclk half-period 64 cycles, rx_load at cycle 1024, rx_data=3C, mosi held 1 throughout.
- Ignored start: pulse start with tx_data=00 at cycle 10 of an active FF transfer -> waveform unchanged, exactly one rx_load.
- Back-to-back: start held high continuously with tx_data=12 then 34 -> rx_load pulses 33 cycles apart, rx_data=12 then matching miso byte, busy low for exactly 1 cycle between bytes.
- Hold: after a transfer yielding 5A, 200 idle cycles with miso toggling -> rx_data stays 5A, rx_load stays 0, sclk stays 0.
